// File: rtl/alu16_reg.sv
// rtl/alu16_reg.sv - 8-function registered ALU with carry-in and zero/negative flags
module alu16_reg #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             C,
   input  logic [2:0]       opcode,
   output logic [WIDTH-1:0] W,
   output logic             zero,
   output logic             negative
);

   logic [WIDTH-1:0] w_d, w_q;
   logic             zero_d, zero_q;
   logic             negative_d, negative_q;
   logic [WIDTH-1:0] c_ext;

   // Carry/borrow-out is discarded, so arithmetic simply wraps at WIDTH bits.
   always_comb begin
      w_d   = '0;
      c_ext = {{(WIDTH-1){1'b0}}, C};
      case (opcode)
         3'b000: w_d = A + B + c_ext;
         3'b001: w_d = A - B - c_ext;
         3'b010: w_d = A & B;
         3'b011: w_d = A | B;
         3'b100: w_d = A ^ B;
         3'b101: w_d = ~A;
         3'b110: w_d = {C, A[WIDTH-1:1]};
         3'b111: w_d = B;
      endcase
      zero_d     = (w_d == '0);
      negative_d = w_d[WIDTH-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_q        <= '0;
         zero_q     <= 1'b1;
         negative_q <= 1'b0;
      end else begin
         w_q        <= w_d;
         zero_q     <= zero_d;
         negative_q <= negative_d;
      end
   end

   assign W        = w_q;
   assign zero     = zero_q;
   assign negative = negative_q;

endmodule

// File: tb/tb_alu16_reg.sv
// tb/tb_alu16_reg.sv - self-checking bench for alu16_reg against an arithmetic reference model
module tb_alu16_reg;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] a_s = '0;
   logic [15:0] b_s = '0;
   logic        c_s = 1'b0;
   logic [2:0]  op_s = '0;
   logic [15:0] w;
   logic        zero;
   logic        negative;

   int tests = 0;
   int fails = 0;

   always #100 clk = ~clk;

   alu16_reg #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst), .A(a_s), .B(b_s), .C(c_s), .opcode(op_s),
      .W(w), .zero(zero), .negative(negative)
   );

   // Reference model: plain integer arithmetic modulo 65536.
   function automatic int model(input int a, input int b, input int c, input int op);
      int r;
      case (op)
         0: r = (a + b + c) % 65536;
         1: r = (a - b - c + 131072) % 65536;
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: r = 65535 - a;
         6: r = c * 32768 + a / 2;
         default: r = b;
      endcase
      return r;
   endfunction

   task automatic step(input logic [15:0] a, input logic [15:0] b, input logic c,
                       input logic [2:0] op, input logic r);
      @(negedge clk);
      a_s = a; b_s = b; c_s = c; op_s = op; rst = r;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      step(16'hFFFF, 16'h1234, 1'b1, 3'b000, 1'b1);
      tests++;
      if ({w, zero, negative} !== {16'h0000, 1'b1, 1'b0}) begin
         fails++;
         $display("FAIL reset: got W=%h z=%b n=%b, want W=0000 z=1 n=0", w, zero, negative);
      end
   endtask

   task automatic test_add();
      step(16'hFFFF, 16'h0001, 1'b0, 3'b000, 1'b0);
      tests++;
      if ({w, zero, negative} !== {16'h0000, 1'b1, 1'b0}) begin
         fails++;
         $display("FAIL add_wrap: got W=%h z=%b n=%b, want W=0000 z=1 n=0", w, zero, negative);
      end
      step(16'hFFFF, 16'h0001, 1'b1, 3'b000, 1'b0);
      tests++;
      if ({w, zero, negative} !== {16'h0001, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL add_carry: got W=%h z=%b n=%b, want W=0001 z=0 n=0", w, zero, negative);
      end
   endtask

   task automatic test_sub();
      step(16'h0000, 16'h0001, 1'b1, 3'b001, 1'b0);
      tests++;
      if ({w, zero, negative} !== {16'hFFFE, 1'b0, 1'b1}) begin
         fails++;
         $display("FAIL sub_borrow: got W=%h z=%b n=%b, want W=FFFE z=0 n=1", w, zero, negative);
      end
      step(16'h1234, 16'h1234, 1'b0, 3'b001, 1'b0);
      tests++;
      if ({w, zero, negative} !== {16'h0000, 1'b1, 1'b0}) begin
         fails++;
         $display("FAIL sub_equal: got W=%h z=%b n=%b, want W=0000 z=1 n=0", w, zero, negative);
      end
   endtask

   task automatic test_logic();
      logic [2:0]  ops [4] = '{3'b010, 3'b011, 3'b100, 3'b101};
      logic [15:0] exp [4] = '{16'h00F0, 16'hFFF0, 16'hFF00, 16'h0F0F};
      logic        expn[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
         // C=1 here: logic ops must ignore it.
         step(16'hF0F0, 16'h0FF0, 1'b1, ops[i], 1'b0);
         tests++;
         if ({w, zero, negative} !== {exp[i], 1'b0, expn[i]}) begin
            fails++;
            $display("FAIL logic_op%0d: got W=%h z=%b n=%b, want W=%h z=0 n=%b",
                     ops[i], w, zero, negative, exp[i], expn[i]);
         end
      end
   endtask

   task automatic test_shift_pass();
      step(16'h8001, 16'h0000, 1'b1, 3'b110, 1'b0);
      tests++;
      if ({w, zero, negative} !== {16'hC000, 1'b0, 1'b1}) begin
         fails++;
         $display("FAIL shr_c1: got W=%h z=%b n=%b, want W=C000 z=0 n=1", w, zero, negative);
      end
      step(16'h8001, 16'h0000, 1'b0, 3'b110, 1'b0);
      tests++;
      if ({w, zero, negative} !== {16'h4000, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL shr_c0: got W=%h z=%b n=%b, want W=4000 z=0 n=0", w, zero, negative);
      end
      step(16'h1234, 16'h8000, 1'b1, 3'b111, 1'b0);
      tests++;
      if ({w, zero, negative} !== {16'h8000, 1'b0, 1'b1}) begin
         fails++;
         $display("FAIL pass_b: got W=%h z=%b n=%b, want W=8000 z=0 n=1", w, zero, negative);
      end
   endtask

   task automatic test_random();
      logic [15:0] a, b, ew;
      logic        c, r, ez, en;
      logic [2:0]  op;
      int          res;
      for (int i = 0; i < 30; i++) begin
         a  = 16'($urandom);
         b  = 16'($urandom);
         c  = 1'($urandom);
         op = 3'($urandom);
         if (i % 10 == 0) b = 16'($urandom_range(0, 3));
         r  = (i == 15);
         step(a, b, c, op, r);
         res = r ? 0 : model(int'(a), int'(b), int'(c), int'(op));
         ew  = res[15:0];
         ez  = (res == 0);
         en  = (res >= 32768);
         tests++;
         if ({w, zero, negative} !== {ew, ez, en}) begin
            fails++;
            $display("FAIL random[%0d] op=%0d a=%h b=%h c=%b rst=%b: got W=%h z=%b n=%b, want W=%h z=%b n=%b",
                     i, op, a, b, c, r, w, zero, negative, ew, ez, en);
         end
         // Change inputs mid-cycle; registered outputs must not move before the edge.
         @(negedge clk);
         a_s = ~a; b_s = ~b; op_s = op + 3'd1;
         #50;
         tests++;
         if ({w, zero, negative} !== {ew, ez, en}) begin
            fails++;
            $display("FAIL hold[%0d]: got W=%h z=%b n=%b, want W=%h z=%b n=%b",
                     i, w, zero, negative, ew, ez, en);
         end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_logic();
      test_shift_pass();
      test_random();
      test_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
